// File: rtl/kernel_pr_fifo_srl_reg_pkg.sv
// Shared constants and elaboration-time helpers for the kernel_pr stream FIFO.
// Imported by the interface, the SRL store and the top level.
package kernel_pr_fifo_pkg;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Address width for an SRL of the given length; never collapses to zero bits.
    function automatic int addr_width(input int entries);
        return (entries > 1) ? clog2(entries) : 1;
    endfunction

    function automatic bit params_ok(input int data_width, input int depth,
                                     input int afull_thresh, input int aempty_thresh);
        return (data_width >= 1) && (depth >= 2) &&
               (afull_thresh >= 1) && (afull_thresh <= depth) &&
               (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/kernel_pr_fifo_srl_reg_if.sv
// Producer/consumer handshake bundle for the kernel_pr stream FIFO.
// The FIFO takes the slave view; whoever feeds and drains it takes the master view.
interface kernel_pr_fifo_srl_reg_if
    import kernel_pr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
);
    localparam int CNT_WIDTH = clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_write_ce;
    logic                  if_full_n;
    logic                  if_almost_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_read_ce;
    logic                  if_empty_n;
    logic                  if_almost_empty_n;
    logic [CNT_WIDTH-1:0]  if_num_data;

    modport slave (
        input  if_din, if_write, if_write_ce, if_read, if_read_ce,
        output if_full_n, if_almost_full_n, if_dout, if_empty_n,
        if_almost_empty_n, if_num_data
    );

    modport master (
        output if_din, if_write, if_write_ce, if_read, if_read_ce,
        input  if_full_n, if_almost_full_n, if_dout, if_empty_n,
        if_almost_empty_n, if_num_data
    );

endinterface

// File: rtl/kernel_pr_fifo_srl_store.sv
// Plain shift-register storage: shift-in at entry 0 on ce, asynchronous read by address.
// Contents are deliberately not reset so the array maps onto SRL primitives.
module kernel_pr_fifo_srl_store
    import kernel_pr_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ENTRIES    = 31,
    parameter int ADDR_WIDTH = addr_width(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [WIDTH-1:0]      shift_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam logic [ADDR_WIDTH:0] ENTRIES_W = (ADDR_WIDTH + 1)'(ENTRIES);

    logic [WIDTH-1:0] srl_q [ENTRIES];
    logic [WIDTH-1:0] srl_d [ENTRIES];

    always_comb begin
        srl_d = srl_q;
        if (ce) begin
            srl_d[0] = shift_in;
            for (int i = 1; i < ENTRIES; i++) begin
                srl_d[i] = srl_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        srl_q <= srl_d;
    end

    // The top never addresses past the last entry; the guard only keeps odd lengths tidy.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < ENTRIES_W) begin
            rd_data = srl_q[rd_addr];
        end
    end

endmodule

// File: rtl/kernel_pr_fifo_srl_reg.sv
// Stream FIFO: SRL storage plus a registered head-of-queue stage, occupancy count and
// registered full/empty/almost flags. if_dout comes straight from a flop.
module kernel_pr_fifo_srl_reg
    import kernel_pr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    kernel_pr_fifo_srl_reg_if.slave   fifo
);

    localparam int CNT_WIDTH  = clog2(DEPTH + 1);
    localparam int SRL_DEPTH  = DEPTH - 1;
    localparam int ADDR_WIDTH = addr_width(SRL_DEPTH);

    if (!params_ok(DATA_WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("kernel_pr_fifo_srl_reg: illegal DATA_WIDTH/DEPTH/threshold parameters");
    end

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  afull_n_q, afull_n_d;
    logic                  aempty_n_q, aempty_n_d;

    logic                  wr, rd;
    logic                  stage_free, srl_nonempty;
    logic                  load_srl, load_bypass, srl_shift;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_rd_data;

    // The SRL holds count-1 entries, so its oldest word sits at count-2.
    always_comb begin
        wr           = fifo.if_write & fifo.if_write_ce & full_n_q;
        rd           = fifo.if_read & fifo.if_read_ce & empty_n_q;
        stage_free   = ~empty_n_q | rd;
        srl_nonempty = count_q > CNT_WIDTH'(1);
        load_srl     = stage_free & srl_nonempty;
        load_bypass  = stage_free & ~srl_nonempty & wr;
        srl_shift    = wr & ~load_bypass;
        srl_addr     = srl_nonempty ? ADDR_WIDTH'(count_q - CNT_WIDTH'(2)) : '0;

        count_d    = count_q + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
        empty_n_d  = count_d != '0;
        full_n_d   = count_d != CNT_WIDTH'(DEPTH);
        afull_n_d  = count_d < CNT_WIDTH'(AFULL_THRESH);
        aempty_n_d = count_d > CNT_WIDTH'(AEMPTY_THRESH);
    end

    always_comb begin
        dout_d = dout_q;
        if (load_srl) begin
            dout_d = srl_rd_data;
        end else if (load_bypass) begin
            dout_d = fifo.if_din;
        end
    end

    kernel_pr_fifo_srl_store #(
        .WIDTH      (DATA_WIDTH),
        .ENTRIES    (SRL_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk      (clk),
        .ce       (srl_shift),
        .shift_in (fifo.if_din),
        .rd_addr  (srl_addr),
        .rd_data  (srl_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            dout_q     <= '0;
            empty_n_q  <= 1'b0;
            full_n_q   <= 1'b1;
            afull_n_q  <= 1'b1;
            aempty_n_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            dout_q     <= dout_d;
            empty_n_q  <= empty_n_d;
            full_n_q   <= full_n_d;
            afull_n_q  <= afull_n_d;
            aempty_n_q <= aempty_n_d;
        end
    end

    assign fifo.if_dout           = dout_q;
    assign fifo.if_num_data       = count_q;
    assign fifo.if_empty_n        = empty_n_q;
    assign fifo.if_full_n         = full_n_q;
    assign fifo.if_almost_full_n  = afull_n_q;
    assign fifo.if_almost_empty_n = aempty_n_q;

endmodule

// File: tb/tb_kernel_pr_fifo_srl_reg.sv
// Bench for kernel_pr_fifo_srl_reg: a DEPTH=32 and a DEPTH=5 instance checked every cycle
// against a queue model (head of queue = if_dout, queue size = occupancy).
module tb_kernel_pr_fifo_srl_reg;

    logic clk;
    logic reset;

    kernel_pr_fifo_srl_reg_if #(.DATA_WIDTH(32), .DEPTH(32)) bus32 ();
    kernel_pr_fifo_srl_reg_if #(.DATA_WIDTH(32), .DEPTH(5))  bus5 ();

    kernel_pr_fifo_srl_reg #(
        .DATA_WIDTH(32), .DEPTH(32), .AFULL_THRESH(28), .AEMPTY_THRESH(2)
    ) dut32 (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus32)
    );

    kernel_pr_fifo_srl_reg #(
        .DATA_WIDTH(32), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(0)
    ) dut5 (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel      = 0;
    int          depth    = 32;
    int          afull    = 28;
    int          aempty   = 2;
    logic [31:0] model_q [$];
    logic [31:0] last_dout = '0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] o_dout, o_num;
        logic        o_empty_n, o_full_n, o_afull_n, o_aempty_n;
        int          cnt;
        if (sel == 0) begin
            o_dout = bus32.if_dout;      o_num = 32'(bus32.if_num_data);
            o_empty_n = bus32.if_empty_n; o_full_n = bus32.if_full_n;
            o_afull_n = bus32.if_almost_full_n; o_aempty_n = bus32.if_almost_empty_n;
        end else begin
            o_dout = bus5.if_dout;       o_num = 32'(bus5.if_num_data);
            o_empty_n = bus5.if_empty_n;  o_full_n = bus5.if_full_n;
            o_afull_n = bus5.if_almost_full_n; o_aempty_n = bus5.if_almost_empty_n;
        end
        cnt = model_q.size();
        checkValue("num_data", o_num, 32'(cnt));
        checkValue("empty_n", 32'(o_empty_n), 32'(cnt != 0));
        checkValue("full_n", 32'(o_full_n), 32'(cnt != depth));
        checkValue("almost_full_n", 32'(o_afull_n), 32'(cnt < afull));
        checkValue("almost_empty_n", 32'(o_aempty_n), 32'(cnt > aempty));
        checkValue("dout", o_dout, last_dout);
    endtask

    // Drive one cycle on the selected FIFO, advance the model across the edge, then check.
    task automatic applyStimulus(input logic rst, input logic w, input logic wce,
                                 input logic [31:0] d, input logic r, input logic rce);
        bit wr_ok, rd_ok;
        reset = rst;
        bus32.if_din = d; bus5.if_din = d;
        bus32.if_write = (sel == 0) ? w : 1'b0;  bus32.if_write_ce = wce;
        bus32.if_read  = (sel == 0) ? r : 1'b0;  bus32.if_read_ce  = rce;
        bus5.if_write  = (sel == 1) ? w : 1'b0;  bus5.if_write_ce  = wce;
        bus5.if_read   = (sel == 1) ? r : 1'b0;  bus5.if_read_ce   = rce;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            last_dout = '0;
        end else begin
            wr_ok = w && wce && (model_q.size() < depth);
            rd_ok = r && rce && (model_q.size() > 0);
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
            if (model_q.size() > 0) last_dout = model_q[0];
        end
        #1;
        checkOutput();
    endtask

    task automatic doReset();                     applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1); endtask
    task automatic doIdle();                      applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1); endtask
    task automatic doWrite(input logic [31:0] d); applyStimulus(1'b0, 1'b1, 1'b1, d,  1'b0, 1'b1); endtask
    task automatic doRead();                      applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b1); endtask
    task automatic doBoth(input logic [31:0] d);  applyStimulus(1'b0, 1'b1, 1'b1, d,  1'b1, 1'b1); endtask

    task automatic randomCycles(input int cycles, input int pw, input int pr);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, $urandom_range(0, 99) < pw, $urandom_range(0, 9) != 0, $urandom,
                          $urandom_range(0, 99) < pr, $urandom_range(0, 9) != 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus32.if_din = '0; bus32.if_write = 1'b0; bus32.if_write_ce = 1'b0;
        bus32.if_read = 1'b0; bus32.if_read_ce = 1'b0;
        bus5.if_din = '0;  bus5.if_write = 1'b0;  bus5.if_write_ce = 1'b0;
        bus5.if_read = 1'b0;  bus5.if_read_ce = 1'b0;

        $display("[TB] DEPTH=32: reset and first write");
        doReset();
        doReset();
        doWrite(32'hA5A5_0001);
        doIdle();
        doRead();
        doRead();

        $display("[TB] DEPTH=32: fill, overflow write, drain");
        for (int i = 0; i < 32; i++) doWrite(32'(i));
        doWrite(32'h0000_DEAD);
        for (int i = 0; i < 33; i++) doRead();

        $display("[TB] DEPTH=32: streaming at occupancy 1, 16, 31");
        doWrite(32'h1000_0000);
        for (int i = 1; i <= 100; i++) doBoth(32'h1000_0000 + 32'(i));
        for (int i = 0; i < 15; i++) doWrite(32'h2000_0000 + 32'(i));
        for (int i = 0; i < 100; i++) doBoth(32'h3000_0000 + 32'(i));
        for (int i = 0; i < 15; i++) doWrite(32'h4000_0000 + 32'(i));
        for (int i = 0; i < 100; i++) doBoth(32'h5000_0000 + 32'(i));

        $display("[TB] DEPTH=32: read+write while full");
        doWrite(32'h6000_0000);
        doBoth(32'h6000_0001);
        doIdle();

        $display("[TB] DEPTH=32: randomized traffic");
        randomCycles(150, 70, 30);
        randomCycles(150, 30, 70);
        randomCycles(100, 50, 50);

        $display("[TB] DEPTH=32: reset with entries and a same-cycle write");
        doReset();
        for (int i = 0; i < 10; i++) doWrite(32'h7000_0000 + 32'(i));
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h7777_7777, 1'b0, 1'b1);
        doWrite(32'h0000_1234);
        doIdle();

        $display("[TB] DEPTH=5: fill, drain, hold last word");
        sel = 1; depth = 5; afull = 4; aempty = 0;
        doReset();
        for (int i = 0; i < 6; i++) doWrite(32'hB000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) doRead();
        doIdle();
        doBoth(32'hB100_0000);
        randomCycles(200, 55, 45);
        randomCycles(100, 80, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
